// File: rtl/atoi2.sv
// Parses "num0\tnum1\n" ASCII lines into two unsigned integers and holds each
// complete record until the consumer takes it. Malformed lines are dropped and flagged.
module atoi2 #(
  parameter int SIZE = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      di,
  input  logic            diValid,
  output logic            diReady,
  output logic [SIZE-1:0] num0,
  output logic [SIZE-1:0] num1,
  output logic            ovf,
  output logic            doValid,
  input  logic            doReady,
  output logic            err
);

  localparam logic [1:0] FIELD0  = 2'd0;
  localparam logic [1:0] FIELD1  = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;
  localparam logic [1:0] DISCARD = 2'd3;

  localparam logic [7:0] TAB = 8'h09;
  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] CR  = 8'h0D;

  localparam int CW = 4;

  logic [1:0]      state, state_nx;
  logic [SIZE-1:0] acc, acc_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            ovf_int, ovf_int_nx;
  logic [SIZE-1:0] num0_nx, num1_nx;
  logic            ovf_nx, do_valid_nx, err_nx;

  logic            accept;
  logic            is_digit, is_tab, is_lf, is_cr;
  logic            have_digits;
  logic [SIZE+3:0] prod;

  assign diReady     = (state != HOLD);
  assign accept      = diValid && diReady;

  assign is_digit    = (di >= 8'h30) && (di <= 8'h39);
  assign is_tab      = (di == TAB);
  assign is_lf       = (di == LF);
  assign is_cr       = (di == CR);
  assign have_digits = (cnt != '0);

  // Four spare bits hold acc*10+9 exactly, so any carry into them means the field wrapped.
  assign prod = {4'd0, acc} * (SIZE+4)'(10) + (SIZE+4)'(di[3:0]);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx    = state;
    acc_nx      = acc;
    cnt_nx      = cnt;
    ovf_int_nx  = ovf_int;
    num0_nx     = num0;
    num1_nx     = num1;
    ovf_nx      = ovf;
    do_valid_nx = doValid;
    err_nx      = 1'b0;

    if (state == HOLD) begin
      if (doReady) begin
        do_valid_nx = 1'b0;
        acc_nx      = '0;
        cnt_nx      = '0;
        ovf_int_nx  = 1'b0;
        state_nx    = FIELD0;
      end
    end else if (accept && !is_cr) begin
      if (state == DISCARD) begin
        if (is_lf) begin
          err_nx   = 1'b1;
          state_nx = FIELD0;
        end
      end else if (is_digit) begin
        acc_nx = prod[SIZE-1:0];
        // Saturate so an arbitrarily long digit run can never look empty.
        if (cnt != '1) cnt_nx = cnt + 1'b1;
        if (prod[SIZE+3:SIZE] != 4'd0) ovf_int_nx = 1'b1;
      end else if ((state == FIELD0) && is_tab && have_digits) begin
        num0_nx  = acc;
        acc_nx   = '0;
        cnt_nx   = '0;
        state_nx = FIELD1;
      end else if ((state == FIELD1) && is_lf && have_digits) begin
        num1_nx     = acc;
        ovf_nx      = ovf_int;
        do_valid_nx = 1'b1;
        state_nx    = HOLD;
      end else begin
        acc_nx     = '0;
        cnt_nx     = '0;
        ovf_int_nx = 1'b0;
        if (is_lf) begin
          err_nx   = 1'b1;
          state_nx = FIELD0;
        end else begin
          state_nx = DISCARD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state   <= FIELD0;
      acc     <= '0;
      cnt     <= '0;
      ovf_int <= 1'b0;
      num0    <= '0;
      num1    <= '0;
      ovf     <= 1'b0;
      doValid <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      acc     <= acc_nx;
      cnt     <= cnt_nx;
      ovf_int <= ovf_int_nx;
      num0    <= num0_nx;
      num1    <= num1_nx;
      ovf     <= ovf_nx;
      doValid <= do_valid_nx;
      err     <= err_nx;
    end
  end

endmodule

// File: tb/tb_atoi2.sv
// Bench for atoi2: 64-bit and 8-bit instances share one byte stream; a line-level
// model predicts every record/err and a per-cycle compare checks both instances.
module tb_atoi2;

  localparam logic [7:0] TAB = 8'h09;
  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] CR  = 8'h0D;
  localparam int NREC = 9;
  localparam int NERR = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] di = 8'h00;
  logic       diValid = 1'b0;
  logic       doReady = 1'b1;

  logic        diReady_64, ovf_64, doValid_64, err_64;
  logic [63:0] num0_64, num1_64;
  logic        diReady_8, ovf_8, doValid_8, err_8;
  logic [7:0]  num0_8, num1_8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  atoi2 #(.SIZE(64)) u_dut64 (
    .clk(clk), .rst(rst), .di(di), .diValid(diValid), .diReady(diReady_64),
    .num0(num0_64), .num1(num1_64), .ovf(ovf_64), .doValid(doValid_64),
    .doReady(doReady), .err(err_64)
  );

  atoi2 #(.SIZE(8)) u_dut8 (
    .clk(clk), .rst(rst), .di(di), .diValid(diValid), .diReady(diReady_8),
    .num0(num0_8), .num1(num1_8), .ovf(ovf_8), .doValid(doValid_8),
    .doReady(doReady), .err(err_8)
  );

  logic [1:0]       rdy, dv, ov, er;
  logic [1:0][63:0] n0, n1;
  assign rdy   = {diReady_8, diReady_64};
  assign dv    = {doValid_8, doValid_64};
  assign ov    = {ovf_8, ovf_64};
  assign er    = {err_8, err_64};
  assign n0[0] = num0_64;
  assign n0[1] = {56'd0, num0_8};
  assign n1[0] = num1_64;
  assign n1[1] = {56'd0, num1_8};

  task automatic check(string name, int k, logic [63:0] got, logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s [inst %0d]: got %0h, want %0h", name, k, got, want);
    end
  endtask

  // ---------------- line-level model ----------------
  typedef enum {EV_NONE, EV_REC, EV_ERR} ev_e;

  int          size_of [2] = '{64, 8};
  string       max_of  [2] = '{"18446744073709551615", "255"};
  string       line_buf [2];
  ev_e         ev [2];
  logic [63:0] e_n0 [2];
  logic [63:0] e_n1 [2];
  logic        e_ov [2];
  logic        was_dv [2];
  logic        hs [2];
  logic        rst_edge = 1'b0;

  function automatic bit all_digits(string s);
    logic [7:0] c;
    if (s.len() == 0) return 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c < 8'h30 || c > 8'h39) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [63:0] wrap_val(string s, int size);
    logic [127:0] a;
    logic [127:0] mask;
    logic [7:0]   c;
    a    = '0;
    mask = (128'd1 << size) - 128'd1;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      a = (a * 128'd10 + 128'(c - 8'h30)) & mask;
    end
    return a[63:0];
  endfunction

  // Decimal string exceeds the largest representable value: compare as digit strings.
  function automatic bit too_big(string s, string mx);
    int    st;
    string t;
    st = 0;
    while (st < s.len() && s[st] == "0") st++;
    t = (st >= s.len()) ? "" : s.substr(st, s.len() - 1);
    return (t.len() > mx.len()) || (t.len() == mx.len() && t > mx);
  endfunction

  task automatic eval_line(int k);
    string s, f0, f1;
    int    ntab, tabpos;
    s = line_buf[k];
    ntab = 0;
    tabpos = -1;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == TAB) begin
        ntab++;
        tabpos = i;
      end
    end
    ev[k] = EV_ERR;
    if (ntab == 1) begin
      f0 = (tabpos == 0) ? "" : s.substr(0, tabpos - 1);
      f1 = (tabpos == s.len() - 1) ? "" : s.substr(tabpos + 1, s.len() - 1);
      if (all_digits(f0) && all_digits(f1)) begin
        ev[k]   = EV_REC;
        e_n0[k] = wrap_val(f0, size_of[k]);
        e_n1[k] = wrap_val(f1, size_of[k]);
        e_ov[k] = too_big(f0, max_of[k]) || too_big(f1, max_of[k]);
      end
    end
  endtask

  always @(posedge clk) begin
    rst_edge = rst;
    for (int k = 0; k < 2; k++) begin
      ev[k]     = EV_NONE;
      was_dv[k] = dv[k];
      hs[k]     = dv[k] && doReady;
      if (rst) begin
        line_buf[k] = "";
      end else if (diValid && rdy[k]) begin
        if (di == LF) begin
          eval_line(k);
          line_buf[k] = "";
        end else if (di != CR) begin
          line_buf[k] = $sformatf("%s%c", line_buf[k], di);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  typedef struct {
    int          k;
    logic [63:0] n0;
    logic [63:0] n1;
    logic        ov;
  } rec_t;

  rec_t log_q[$];
  int   rises [2] = '{0, 0};
  int   errs  [2] = '{0, 0};

  always @(negedge clk) begin
    rec_t r;
    for (int k = 0; k < 2; k++) begin
      if (er[k]) errs[k]++;
      if (dv[k] && !was_dv[k]) rises[k]++;
      if (rst_edge) begin
        check("rst_doValid", k, dv[k], 1'b0);
        check("rst_err", k, er[k], 1'b0);
        check("rst_ovf", k, ov[k], 1'b0);
        check("rst_num0", k, n0[k], 64'd0);
        check("rst_num1", k, n1[k], 64'd0);
        check("rst_diReady", k, rdy[k], 1'b1);
      end else begin
        case (ev[k])
          EV_REC: begin
            check("rec_doValid", k, dv[k], 1'b1);
            check("rec_err", k, er[k], 1'b0);
            check("rec_num0", k, n0[k], e_n0[k]);
            check("rec_num1", k, n1[k], e_n1[k]);
            check("rec_ovf", k, ov[k], e_ov[k]);
            r.k = k; r.n0 = n0[k]; r.n1 = n1[k]; r.ov = ov[k];
            log_q.push_back(r);
          end
          EV_ERR: begin
            check("err_pulse", k, er[k], 1'b1);
            check("err_doValid", k, dv[k], 1'b0);
          end
          default: begin
            check("idle_err", k, er[k], 1'b0);
            if (was_dv[k] && !hs[k]) begin
              check("hold_doValid", k, dv[k], 1'b1);
              check("hold_num0", k, n0[k], e_n0[k]);
              check("hold_num1", k, n1[k], e_n1[k]);
              check("hold_ovf", k, ov[k], e_ov[k]);
            end else begin
              check("idle_doValid", k, dv[k], 1'b0);
            end
          end
        endcase
        check("diReady", k, rdy[k], !dv[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(logic [7:0] b);
    bit done;
    int waited;
    done = 1'b0;
    waited = 0;
    while (!done) begin
      @(negedge clk);
      di = b;
      diValid = 1'b1;
      if (diReady_64) begin
        done = 1'b1;
      end else if (++waited > 50) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: byte %0h not accepted after %0d cycles, want accepted", b, waited);
        done = 1'b1;
      end
      @(posedge clk);
    end
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      diValid = 1'b0;
    end
  endtask

  logic [63:0] lit_n0 [2][NREC] = '{
    '{64'd12, 64'd7, 64'd9, 64'd3, 64'd256, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd4},
    '{64'd12, 64'd7, 64'd9, 64'd3, 64'd0,   64'd1, 64'd255,                64'd0, 64'd4}};
  logic [63:0] lit_n1 [2][NREC] = '{
    '{64'd345, 64'd8, 64'd10, 64'd4, 64'd255, 64'd2, 64'd7, 64'd0, 64'd5},
    '{64'd89,  64'd8, 64'd10, 64'd4, 64'd255, 64'd2, 64'd7, 64'd0, 64'd5}};
  logic        lit_ov [2][NREC] = '{
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
    '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}};

  initial begin
    int idx [2];
    int w;
    idx = '{0, 0};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    doReady = 1'b1;
    send_str("12\t345\n");
    idle(3);

    // Consumer stalls 5 cycles on the first record.
    doReady = 1'b0;
    fork
      send_str("7\t8\n9\t10\n");
      begin
        w = 0;
        while (!doValid_64 && w < 100) begin
          @(negedge clk);
          w++;
        end
        if (w >= 100) begin
          tests++;
          fails++;
          $display("FAIL stall_wait: doValid low after %0d cycles, want high", w);
        end
        repeat (5) @(negedge clk);
        doReady = 1'b1;
      end
    join
    idle(3);

    send_str("1a\t2\n3\t4\n");
    idle(3);
    send_str("\t5\n5\n5\t\n5\t6\t\n");
    idle(3);
    send_str("256\t255\n1\t2\015\n");
    idle(3);
    send_str("18446744073709551615\t007\n18446744073709551616\t0\n");
    idle(3);

    // Reset mid-line: the partial line vanishes silently.
    send_str("12\t3");
    @(negedge clk);
    diValid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_str("4\t5\n");
    idle(4);

    foreach (log_q[i]) begin
      int k;
      k = log_q[i].k;
      if (idx[k] < NREC) begin
        check("lit_num0", k, log_q[i].n0, lit_n0[k][idx[k]]);
        check("lit_num1", k, log_q[i].n1, lit_n1[k][idx[k]]);
        check("lit_ovf", k, log_q[i].ov, lit_ov[k][idx[k]]);
      end
      idx[k]++;
    end
    for (int k = 0; k < 2; k++) begin
      check("lit_rec_count", k, idx[k], NREC);
      check("lit_doValid_rises", k, rises[k], NREC);
      check("lit_err_pulses", k, errs[k], NERR);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
